// File: rtl/key_beep_if.sv
// Key/beeper bundle between the debouncer side and key_beep_ctrl.
// The master drives debounced key strobes/levels; the slave (the controller)
// drives the beeper and the granted-event report.
interface key_beep_if #(
  parameter int KEY_NUM = 4,
  parameter int IDX_W   = 3
);
  logic [KEY_NUM-1:0] key_flag;
  logic [KEY_NUM-1:0] key_value;
  logic               beep;
  logic               busy;
  logic               evt_valid;
  logic [IDX_W-1:0]   evt_key;
  logic               evt_long;

  modport master (
    output key_flag, key_value,
    input  beep, busy, evt_valid, evt_key, evt_long
  );

  modport slave (
    input  key_flag, key_value,
    output beep, busy, evt_valid, evt_key, evt_long
  );
endinterface

// File: rtl/key_beep_ctrl.sv
// Key event controller and beeper arbiter.
// Each key classifies presses as short or long and keeps one pending event;
// a single IDLE/TONE/GAP engine grants the lowest pending key, reports it for
// one cycle and plays (i+1) short tones or one 4x-long tone, each followed by
// a silent gap.
module key_beep_ctrl #(
  parameter int KEY_NUM     = 4,
  parameter int BEEP_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int IDX_W       = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  key_beep_if.slave  bus
);

  localparam logic [31:0] TONE_S   = 32'(BEEP_CYCLES);
  localparam logic [31:0] TONE_L   = 32'(4 * BEEP_CYCLES);
  localparam logic [31:0] GAP_LEN  = 32'(GAP_CYCLES);
  localparam logic [31:0] HOLD_MAX = 32'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t             state_q, state_d;
  logic [KEY_NUM-1:0] held_q, held_d;
  logic [KEY_NUM-1:0] long_fired_q, long_fired_d;
  logic [KEY_NUM-1:0] pend_q, pend_d;
  logic [KEY_NUM-1:0] pend_long_q, pend_long_d;
  logic [31:0]        hold_cnt_q [KEY_NUM];
  logic [31:0]        hold_cnt_d [KEY_NUM];
  logic [31:0]        cnt_q, cnt_d;
  logic [3:0]         tones_q, tones_d;
  logic               tone_long_q, tone_long_d;
  logic               beep_q, beep_d;
  logic               evt_valid_q, evt_valid_d;
  logic               evt_long_q, evt_long_d;
  logic [IDX_W-1:0]   evt_key_q, evt_key_d;

  logic               grant_vld;
  logic               grant_go;
  logic               grant_long;
  logic [IDX_W-1:0]   grant_idx;
  logic [KEY_NUM-1:0] grant_oh;
  logic               fire;

  // Fixed-priority pick of the lowest pending key
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_long = 1'b0;
    grant_oh   = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_vld   = 1'b1;
        grant_idx   = IDX_W'(i);
        grant_long  = pend_long_q[i];
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign grant_go = grant_vld && (state_q == IDLE);

  // Per-key press tracking; a new event setting pend wins over the grant clear
  always_comb begin
    held_d       = held_q;
    long_fired_d = long_fired_q;
    pend_d       = pend_q;
    pend_long_d  = pend_long_q;
    hold_cnt_d   = hold_cnt_q;
    fire         = 1'b0;
    for (int i = 0; i < KEY_NUM; i++) begin
      fire = held_q[i] && !long_fired_q[i] && (hold_cnt_q[i] == HOLD_MAX);
      if (held_q[i] && (hold_cnt_q[i] != HOLD_MAX)) hold_cnt_d[i] = hold_cnt_q[i] + 32'd1;
      if (grant_go && grant_oh[i]) pend_d[i] = 1'b0;
      if (fire) begin
        pend_d[i]       = 1'b1;
        pend_long_d[i]  = 1'b1;
        long_fired_d[i] = 1'b1;
      end
      if (bus.key_flag[i] && !bus.key_value[i]) begin
        held_d[i]       = 1'b1;
        hold_cnt_d[i]   = '0;
        long_fired_d[i] = 1'b0;
      end else if (bus.key_flag[i] && held_q[i]) begin
        held_d[i] = 1'b0;
        // A release after the long event already fired produces nothing
        if (!long_fired_q[i] && !fire) begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = 1'b0;
        end
      end
    end
  end

  // Key tracker state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      held_q       <= '0;
      long_fired_q <= '0;
      pend_q       <= '0;
      pend_long_q  <= '0;
      for (int i = 0; i < KEY_NUM; i++) hold_cnt_q[i] <= '0;
    end else begin
      held_q       <= held_d;
      long_fired_q <= long_fired_d;
      pend_q       <= pend_d;
      pend_long_q  <= pend_long_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Beeper FSM next state; counter runs from length-1 down to 0
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tones_d     = tones_q;
    tone_long_d = tone_long_q;
    beep_d      = beep_q;
    evt_valid_d = 1'b0;
    evt_key_d   = evt_key_q;
    evt_long_d  = evt_long_q;
    case (state_q)
      IDLE: begin
        beep_d = 1'b0;
        if (grant_vld) begin
          state_d     = TONE;
          beep_d      = 1'b1;
          evt_valid_d = 1'b1;
          evt_key_d   = grant_idx;
          evt_long_d  = grant_long;
          tone_long_d = grant_long;
          tones_d     = grant_long ? 4'd1 : 4'(grant_idx) + 4'd1;
          cnt_d       = (grant_long ? TONE_L : TONE_S) - 32'd1;
        end
      end
      TONE: begin
        beep_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          beep_d  = 1'b0;
          tones_d = tones_q - 4'd1;
          cnt_d   = GAP_LEN - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      GAP: begin
        beep_d = 1'b0;
        if (cnt_q == '0) begin
          if (tones_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            state_d = TONE;
            beep_d  = 1'b1;
            cnt_d   = (tone_long_q ? TONE_L : TONE_S) - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        beep_d  = 1'b0;
      end
    endcase
  end

  // Beeper FSM registers; reset silences the beeper immediately
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tones_q     <= '0;
      tone_long_q <= 1'b0;
      beep_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tones_q     <= tones_d;
      tone_long_q <= tone_long_d;
      beep_q      <= beep_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_long_q  <= evt_long_d;
    end
  end

  assign bus.beep      = beep_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_key   = evt_key_q;
  assign bus.evt_long  = evt_long_q;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Testbench for key_beep_ctrl: directed scenarios plus random key activity,
// every cycle compared against an event/schedule-level reference model.
module tb_key_beep_ctrl;
  localparam int KN = 4;
  localparam int IW = 3;
  localparam int B  = 4;
  localparam int G  = 2;
  localparam int LG = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_beep_if #(.KEY_NUM(KN), .IDX_W(IW)) bus ();

  key_beep_ctrl #(
    .KEY_NUM(KN), .BEEP_CYCLES(B), .GAP_CYCLES(G), .LONG_CYCLES(LG), .IDX_W(IW)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: key state as press timestamps, beeper as a schedule
  bit          m_held  [KN];
  int          m_pedge [KN];
  bit          m_lf    [KN];
  bit          m_pend  [KN];
  bit          m_plong [KN];
  bit          m_active;
  int          m_start, m_n, m_len, m_k;
  logic        m_beep, m_busy, m_evt, m_long;
  logic [IW-1:0] m_key;

  task automatic model_reset();
    for (int i = 0; i < KN; i++) begin
      m_held[i] = 0; m_pedge[i] = 0; m_lf[i] = 0; m_pend[i] = 0; m_plong[i] = 0;
    end
    m_active = 0; m_start = 0; m_n = 0; m_len = 0;
    m_beep = 0; m_busy = 0; m_evt = 0; m_key = '0; m_long = 0;
  endtask

  task automatic model_step();
    int  span, off, gi;
    bit  idle, fire;
    m_k++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    span = m_n * (m_len + G);
    idle = !m_active || ((m_k - 1 - m_start) >= span);
    m_evt = 0;
    gi = -1;
    for (int i = KN - 1; i >= 0; i--) if (m_pend[i]) gi = i;
    if (idle && gi >= 0) begin
      m_evt    = 1;
      m_key    = IW'(gi);
      m_long   = m_plong[gi];
      m_pend[gi] = 0;
      m_active = 1;
      m_start  = m_k;
      m_n      = m_plong[gi] ? 1 : gi + 1;
      m_len    = m_plong[gi] ? 4 * B : B;
    end
    for (int i = 0; i < KN; i++) begin
      fire = m_held[i] && !m_lf[i] && ((m_k - m_pedge[i]) == LG);
      if (fire) begin m_pend[i] = 1; m_plong[i] = 1; m_lf[i] = 1; end
      if (bus.key_flag[i] && !bus.key_value[i]) begin
        m_held[i] = 1; m_pedge[i] = m_k; m_lf[i] = 0;
      end else if (bus.key_flag[i] && m_held[i]) begin
        m_held[i] = 0;
        if (!m_lf[i]) begin m_pend[i] = 1; m_plong[i] = 0; end
      end
    end
    span   = m_n * (m_len + G);
    off    = m_k - m_start;
    m_busy = m_active && (off < span);
    m_beep = m_busy && ((off % (m_len + G)) < m_len);
  endtask

  function automatic logic [6:0] dut_vec();
    return {bus.beep, bus.busy, bus.evt_valid, bus.evt_key, bus.evt_long};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_beep, m_busy, m_evt, m_key, m_long};
  endfunction

  // One clock: inputs are already stable, model follows the edge, sample at negedge
  task automatic drive(input logic [KN-1:0] f, input logic [KN-1:0] v);
    bus.key_flag  = f;
    bus.key_value = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [KN-1:0] f, v;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      f = KN'($urandom); v = KN'($urandom);
      drive(f, v);
      checks++;
      if (dut_vec() !== 7'b0) begin
        errors++; $display("FAIL reset_outputs cyc %0d: dut=%b want=%b", c, dut_vec(), 7'b0);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      drive('0, '1);
      checks++;
      if (bus.beep !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_quiet cyc %0d: dut=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_short_key2();
    logic [KN-1:0] f, v;
    int evt_cyc = -1, nevt = 0, nbeep = 0, rises = 0;
    logic prev = 1'b0;
    logic [IW-1:0] k = '0;
    logic l = 1'b0;
    for (int c = 0; c < 45; c++) begin
      f = '0; v = '1;
      if (c == 10) begin f[2] = 1'b1; v[2] = 1'b0; end
      if (c == 15) begin f[2] = 1'b1; v[2] = 1'b1; end
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL short_model cyc %0d: dut=%b want=%b", c + 1, dut_vec(), exp_vec());
      end
      if (bus.evt_valid === 1'b1) begin nevt++; evt_cyc = c + 1; k = bus.evt_key; l = bus.evt_long; end
      if (bus.beep === 1'b1) nbeep++;
      if (bus.beep === 1'b1 && !prev) rises++;
      prev = bus.beep;
    end
    checks++;
    if (evt_cyc !== 17 || nevt !== 1) begin
      errors++; $display("FAIL short_evt_time: got cyc %0d n %0d want cyc 17 n 1", evt_cyc, nevt);
    end
    checks++;
    if (k !== 3'd2 || l !== 1'b0) begin
      errors++; $display("FAIL short_evt_fields: got key %0d long %0d want key 2 long 0", k, l);
    end
    checks++;
    if (nbeep !== 12 || rises !== 3) begin
      errors++; $display("FAIL short_beeps: got %0d cycles %0d bursts want 12 cycles 3 bursts", nbeep, rises);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL short_busy_end: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_long_key0();
    logic [KN-1:0] f, v;
    int evt_cyc = -1, nevt = 0, nbeep = 0;
    logic [IW-1:0] k = '1;
    logic l = 1'b0;
    for (int c = 0; c < 90; c++) begin
      f = '0; v = '1;
      if (c == 10) begin f[0] = 1'b1; v[0] = 1'b0; end
      if (c == 50) begin f[0] = 1'b1; v[0] = 1'b1; end
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL long_model cyc %0d: dut=%b want=%b", c + 1, dut_vec(), exp_vec());
      end
      if (bus.evt_valid === 1'b1) begin nevt++; evt_cyc = c + 1; k = bus.evt_key; l = bus.evt_long; end
      if (bus.beep === 1'b1) nbeep++;
    end
    checks++;
    if (nevt !== 1 || evt_cyc !== 32) begin
      errors++; $display("FAIL long_evt_time: got cyc %0d n %0d want cyc 32 n 1", evt_cyc, nevt);
    end
    checks++;
    if (k !== 3'd0 || l !== 1'b1) begin
      errors++; $display("FAIL long_evt_fields: got key %0d long %0d want key 0 long 1", k, l);
    end
    checks++;
    if (nbeep !== 16) begin
      errors++; $display("FAIL long_beeps: got %0d want 16", nbeep);
    end
  endtask

  task automatic test_priority();
    logic [KN-1:0] f, v;
    int keys[$];
    int cycs[$];
    for (int c = 0; c < 65; c++) begin
      f = '0; v = '1;
      case (c)
        2:  begin f[3] = 1'b1; v[3] = 1'b0; end
        4:  begin f[3] = 1'b1; v[3] = 1'b1; end
        8:  begin f[1] = 1'b1; v[1] = 1'b0; end
        10: begin f[1] = 1'b1; v[1] = 1'b1; end
        12: begin f[0] = 1'b1; v[0] = 1'b0; end
        13: begin f[0] = 1'b1; v[0] = 1'b1; end
        default: ;
      endcase
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL prio_model cyc %0d: dut=%b want=%b", c + 1, dut_vec(), exp_vec());
      end
      if (bus.evt_valid === 1'b1) begin keys.push_back(int'(bus.evt_key)); cycs.push_back(c + 1); end
    end
    checks++;
    if (keys.size() !== 3) begin
      errors++; $display("FAIL prio_count: got %0d want 3", keys.size());
    end else begin
      checks++;
      if (keys[0] !== 3 || keys[1] !== 0 || keys[2] !== 1) begin
        errors++; $display("FAIL prio_order: got %0d,%0d,%0d want 3,0,1", keys[0], keys[1], keys[2]);
      end
      checks++;
      if (cycs[0] !== 6 || cycs[1] !== 31 || cycs[2] !== 38) begin
        errors++; $display("FAIL prio_times: got %0d,%0d,%0d want 6,31,38", cycs[0], cycs[1], cycs[2]);
      end
    end
  endtask

  task automatic test_overwrite_same_cycle();
    logic [KN-1:0] f, v;
    int keys[$];
    int lngs[$];
    int cycs[$];
    int want_k[4] = '{3, 1, 1, 1};
    int want_l[4] = '{0, 1, 0, 0};
    int want_c[4] = '{4, 29, 48, 61};
    for (int c = 0; c < 85; c++) begin
      f = '0; v = '1;
      case (c)
        1:  begin f[3] = 1'b1; v[3] = 1'b0; end
        2:  begin f[3] = 1'b1; v[3] = 1'b1; end
        3, 5, 30, 33: begin f[1] = 1'b1; v[1] = 1'b0; end
        4, 28, 31, 47: begin f[1] = 1'b1; v[1] = 1'b1; end
        default: ;
      endcase
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovw_model cyc %0d: dut=%b want=%b", c + 1, dut_vec(), exp_vec());
      end
      if (bus.evt_valid === 1'b1) begin
        keys.push_back(int'(bus.evt_key)); lngs.push_back(int'(bus.evt_long)); cycs.push_back(c + 1);
      end
    end
    checks++;
    if (keys.size() !== 4) begin
      errors++; $display("FAIL ovw_count: got %0d want 4", keys.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (keys[j] !== want_k[j] || lngs[j] !== want_l[j] || cycs[j] !== want_c[j]) begin
          errors++;
          $display("FAIL ovw_evt%0d: got key %0d long %0d cyc %0d want key %0d long %0d cyc %0d",
                   j, keys[j], lngs[j], cycs[j], want_k[j], want_l[j], want_c[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [KN-1:0] f, v;
    for (int c = 0; c < 3000; c++) begin
      f = '0; v = '1;
      for (int i = 0; i < KN; i++) begin
        if ($urandom_range(0, 23) == 0) begin f[i] = 1'b1; v[i] = 1'($urandom_range(0, 1)); end
      end
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model step %0d: dut=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    drive('1, '1);
    for (int c = 0; c < 150; c++) begin
      drive('0, '1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_drain step %0d: dut=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_tone();
    logic [KN-1:0] f, v;
    int nevt = 0, nbeep = 0;
    for (int c = 0; c < 5; c++) begin
      f = '0; v = '1;
      if (c == 1) begin f[0] = 1'b1; v[0] = 1'b0; end
      if (c == 2) begin f = 4'b0101; v = 4'b1011; end
      if (c == 3) begin f[2] = 1'b1; v[2] = 1'b1; end
      drive(f, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_pre cyc %0d: dut=%b want=%b", c + 1, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.beep !== 1'b1) begin
      errors++; $display("FAIL midrst_tone_on: got %b want 1", bus.beep);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.beep !== 1'b0 || bus.busy !== 1'b0 || bus.evt_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got beep %b busy %b evt %b want 0 0 0",
                         bus.beep, bus.busy, bus.evt_valid);
    end
    @(negedge clk);
    drive('0, '1);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive('0, '1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_post cyc %0d: dut=%b want=%b", c, dut_vec(), exp_vec());
      end
      if (bus.evt_valid === 1'b1) nevt++;
      if (bus.beep === 1'b1) nbeep++;
    end
    checks++;
    if (nevt !== 0 || nbeep !== 0) begin
      errors++; $display("FAIL midrst_no_resume: got %0d events %0d beep cycles want 0 0", nevt, nbeep);
    end
  endtask

  initial begin
    bus.key_flag  = '0;
    bus.key_value = '1;
    m_k = 0;
    model_reset();
    test_reset();
    test_short_key2();
    test_long_key0();
    test_priority();
    test_overwrite_same_cycle();
    test_random();
    test_reset_mid_tone();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
